// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: command sequencer driving a WIDTH-bit universal shift register.
// Accepts one command per valid/ready handshake (load, logical shift, rotate,
// arithmetic shift) with a repeat count, steps the register for the required
// number of cycles, then pulses done.
// Ports:
//   clock, resetn            rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_op/count/data/fill   command payload
//   reg_q                    shift register parallel output (fill feedback)
//   sr_enable, sr_s1, sr_s0  shift register enable and mode select
//   sr_pin                   parallel-load word
//   sr_serialinr/l           serial fill bits for right/left shifts
//   busy, done               status: busy in RUN/DONE, one-cycle done pulse
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNTW-1:0]  cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] reg_q,
  output logic             sr_enable,
  output logic             sr_s1,
  output logic             sr_s0,
  output logic [WIDTH-1:0] sr_pin,
  output logic             sr_serialinr,
  output logic             sr_serialinl,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [CNTW-1:0]  r_rem;
  logic [WIDTH-1:0] r_data;
  logic             r_fill;
  logic             w_accept;
  logic             w_zero_work;
  logic             w_unused;

  // Middle bits of reg_q are never needed for fill generation.
  assign w_unused = ^reg_q;

  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  // Commands that never touch the register skip RUN entirely.
  assign w_zero_work = (cmd_op == OP_HOLD) || (cmd_op == OP_RSVD) ||
                       ((cmd_op != OP_LOAD) && (cmd_count == '0));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Latched command and remaining-cycle counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_op   <= OP_HOLD;
      r_rem  <= '0;
      r_data <= '0;
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_op   <= cmd_op;
      r_rem  <= (cmd_op == OP_LOAD) ? CNTW'(1) : cmd_count;
      r_data <= cmd_data;
      r_fill <= cmd_fill;
    end else if (r_state == ST_RUN) begin
      r_rem  <= r_rem - CNTW'(1);
    end
  end

  // Next state and Moore decode; rotate/arithmetic fills pass reg_q through.
  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    sr_enable    = 1'b0;
    sr_s1        = 1'b0;
    sr_s0        = 1'b0;
    sr_pin       = '0;
    sr_serialinr = 1'b0;
    sr_serialinl = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (w_accept) w_state_nxt = w_zero_work ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        sr_enable = 1'b1;
        if (r_rem == CNTW'(1)) w_state_nxt = ST_DONE;
        case (r_op)
          OP_SHR:  begin sr_s0 = 1'b1; sr_serialinr = r_fill;         end
          OP_SHL:  begin sr_s1 = 1'b1; sr_serialinl = r_fill;         end
          OP_LOAD: begin sr_s1 = 1'b1; sr_s0 = 1'b1; sr_pin = r_data; end
          OP_ROR:  begin sr_s0 = 1'b1; sr_serialinr = reg_q[0];       end
          OP_ROL:  begin sr_s1 = 1'b1; sr_serialinl = reg_q[WIDTH-1]; end
          OP_ASR:  begin sr_s0 = 1'b1; sr_serialinr = reg_q[WIDTH-1]; end
          default: ;
        endcase
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 4-bit universal shift
// register closing the reg_q feedback loop.
module tb_shift_seq_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNTW  = 3;

  logic             clock = 1'b0;
  logic             resetn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNTW-1:0]  cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic [WIDTH-1:0] sr_q = '0;
  logic             sr_enable, sr_s1, sr_s0;
  logic [WIDTH-1:0] sr_pin;
  logic             sr_serialinr, sr_serialinl;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .reg_q(sr_q),
    .sr_enable(sr_enable), .sr_s1(sr_s1), .sr_s0(sr_s0), .sr_pin(sr_pin),
    .sr_serialinr(sr_serialinr), .sr_serialinl(sr_serialinl),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Downstream universal shift register.
  always @(posedge clock) begin
    if (sr_enable) begin
      case ({sr_s1, sr_s0})
        2'b01:   sr_q <= {sr_serialinr, sr_q[WIDTH-1:1]};
        2'b10:   sr_q <= {sr_q[WIDTH-2:0], sr_serialinl};
        2'b11:   sr_q <= sr_pin;
        default: sr_q <= sr_q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [2:0] op);
    case (op)
      3'b001, 3'b100, 3'b110: exp_sel = 2'b01;
      3'b010, 3'b101:         exp_sel = 2'b10;
      3'b011:                 exp_sel = 2'b11;
      default:                exp_sel = 2'b00;
    endcase
  endfunction

  // Present a command for one cycle, then follow it through n RUN cycles,
  // the DONE cycle and the return to IDLE.
  task automatic do_cmd(input logic [2:0] op, input logic [CNTW-1:0] cnt,
                        input logic [WIDTH-1:0] data, input logic fill, input int n);
    logic er, el;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = data; cmd_fill = fill;
    chk("ready_before", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      er = 1'b0; el = 1'b0;
      case (op)
        3'b001: er = fill;
        3'b010: el = fill;
        3'b100: er = sr_q[0];
        3'b101: el = sr_q[WIDTH-1];
        3'b110: er = sr_q[WIDTH-1];
        default: ;
      endcase
      chk("run_enable", 32'(sr_enable), 32'd1);
      chk("run_sel", 32'({sr_s1, sr_s0}), 32'(exp_sel(op)));
      chk("run_ready", 32'(cmd_ready), 32'd0);
      chk("run_done", 32'(done), 32'd0);
      chk("run_sinr", 32'(sr_serialinr), 32'(er));
      chk("run_sinl", 32'(sr_serialinl), 32'(el));
      chk("run_pin", 32'(sr_pin), (op == 3'b011) ? 32'(data) : 32'd0);
      @(negedge clock);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_enable", 32'(sr_enable), 32'd0);
    chk("done_ready", 32'(cmd_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_count = CNTW'($urandom);
    cmd_data = WIDTH'($urandom); cmd_fill = 1'($urandom);
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_enable", 32'(sr_enable), 32'd0);
    chk("rst_sel", 32'({sr_s1, sr_s0}), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pin", 32'(sr_pin), 32'd0);
    chk("rst_fill", 32'({sr_serialinr, sr_serialinl}), 32'd0);
    cmd_valid = 1'b0;
    resetn = 1'b1;

    // Load 1010, count ignored.
    do_cmd(3'b011, 3'd5, 4'b1010, 1'b0, 1);
    chk("load_reg", 32'(sr_q), 32'hA);

    // Clear, then logical shift right x3 with fill 1.
    do_cmd(3'b011, 3'd0, 4'b0000, 1'b0, 1);
    chk("clear_reg", 32'(sr_q), 32'h0);
    do_cmd(3'b001, 3'd3, 4'b0000, 1'b1, 3);
    chk("shr_reg", 32'(sr_q), 32'hE);

    // Shift left x2 with fill 1: 1110 -> 1101 -> 1011.
    do_cmd(3'b010, 3'd2, 4'b0000, 1'b1, 2);
    chk("shl_reg", 32'(sr_q), 32'hB);

    // Rotate left x4 from 1001 returns to 1001.
    do_cmd(3'b011, 3'd0, 4'b1001, 1'b0, 1);
    do_cmd(3'b101, 3'd4, 4'b0000, 1'b0, 4);
    chk("rol_reg", 32'(sr_q), 32'h9);

    // Rotate right x1 from 1001 -> 1100.
    do_cmd(3'b100, 3'd1, 4'b0000, 1'b0, 1);
    chk("ror_reg", 32'(sr_q), 32'hC);

    // Arithmetic right x2 from 1000 -> 1110.
    do_cmd(3'b011, 3'd0, 4'b1000, 1'b0, 1);
    do_cmd(3'b110, 3'd2, 4'b0000, 1'b0, 2);
    chk("asr_reg", 32'(sr_q), 32'hE);

    // Zero-work commands: count-0 shift, hold, reserved.
    do_cmd(3'b001, 3'd0, 4'b0000, 1'b1, 0);
    chk("cnt0_reg", 32'(sr_q), 32'hE);
    do_cmd(3'b000, 3'd5, 4'b0000, 1'b1, 0);
    do_cmd(3'b111, 3'd5, 4'b0000, 1'b1, 0);
    chk("hold_reg", 32'(sr_q), 32'hE);

    // cmd_valid held across RUN: re-accepted only from IDLE.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_count = 3'd2; cmd_fill = 1'b0;
    @(negedge clock);
    chk("hold_run1", 32'(sr_enable), 32'd1);
    chk("hold_rdy1", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    chk("hold_run2", 32'(sr_enable), 32'd1);
    @(negedge clock);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_rdy_done", 32'(cmd_ready), 32'd0);
    @(negedge clock);
    chk("hold_idle", 32'(cmd_ready), 32'd1);
    chk("hold_idle_en", 32'(sr_enable), 32'd0);
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("hold_reaccept", 32'(sr_enable), 32'd1);
    repeat (3) @(negedge clock);
    chk("hold_back_idle", 32'(cmd_ready), 32'd1);
    chk("hold_reg", 32'(sr_q), 32'h0);

    // Reset mid-RUN on a count-7 shift.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_count = 3'd7; cmd_fill = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("abort_running", 32'(sr_enable), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_enable", 32'(sr_enable), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk("abort_idle", 32'(cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
